// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling FIFO. It holds {pc, ins} pairs in order, absorbs
// decode stalls, and drops everything on a redirect flush.
module if_id_buffer #(
    parameter int               XLEN    = 32,
    parameter int               DEPTH   = 2,
    parameter logic [XLEN-1:0]  NOP_INS = 32'h00000013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      f_valid,
    input  logic [XLEN-1:0]           f_pc,
    input  logic [XLEN-1:0]           f_ins,
    output logic                      f_ready,
    output logic                      d_valid,
    output logic [XLEN-1:0]           d_pc,
    output logic [XLEN-1:0]           d_ins,
    input  logic                      d_ready,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   occ;
    logic            push;
    logic            pop;
    logic            clear;

    // Ready depends only on registered occupancy, so a pop cannot open a slot
    // for a push in the same cycle.
    assign f_ready = (occ != FULL_CNT);
    assign d_valid = (occ != '0);
    assign count   = occ;

    assign push  = f_valid && f_ready;
    assign pop   = d_valid && d_ready;
    assign clear = rst || flush;

    assign d_pc  = d_valid ? pc_mem[rd_ptr]  : '0;
    assign d_ins = d_valid ? ins_mem[rd_ptr] : NOP_INS;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is not reset. A push that coincides with a flush is discarded
    // and does not write the array.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem[wr_ptr]  <= f_pc;
            ins_mem[wr_ptr] <= f_ins;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer. A queue-based model of an ordered
// buffer with a fixed capacity tracks the expected outputs.
module tb_if_id_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] NOP = 32'h00000013;

    logic            clk = 1'b0;
    logic            rst;
    logic            f_valid;
    logic [XLEN-1:0] f_pc;
    logic [XLEN-1:0] f_ins;
    logic            f_ready;
    logic            d_valid;
    logic [XLEN-1:0] d_pc;
    logic [XLEN-1:0] d_ins;
    logic            d_ready;
    logic            flush;
    logic [CW-1:0]   count;

    int pass_cnt = 0;
    int total    = 0;

    logic [XLEN-1:0] q_pc[$];
    logic [XLEN-1:0] q_ins[$];
    logic [XLEN-1:0] popped[$];

    if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INS(NOP)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_ins(f_ins), .f_ready(f_ready),
        .d_valid(d_valid), .d_pc(d_pc), .d_ins(d_ins), .d_ready(d_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired, passed %0d of %0d", pass_cnt, total);
        $fatal(1, "watchdog");
    end

    // Advance one edge and apply the reference behaviour: capacity DEPTH,
    // accept only when not full before the edge, pop only when non-empty.
    task automatic tick();
        bit do_push, do_pop;
        do_push = f_valid && (q_pc.size() < DEPTH);
        do_pop  = d_ready && (q_pc.size() > 0);
        @(posedge clk);
        #1;
        if (rst || flush) begin
            q_pc.delete();
            q_ins.delete();
        end else begin
            if (do_pop) begin
                popped.push_back(q_pc[0]);
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(f_pc);
                q_ins.push_back(f_ins);
            end
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        f_pc = '0; f_ins = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (f_ready !== 1'b1) $display("FAIL reset_f_ready: got %b want 1", f_ready); else pass_cnt++;
        total++; if (d_valid !== 1'b0) $display("FAIL reset_d_valid: got %b want 0", d_valid); else pass_cnt++;
        total++; if (d_ins !== 32'h00000013) $display("FAIL reset_d_ins: got %h want 00000013", d_ins); else pass_cnt++;
        total++; if (d_pc !== '0) $display("FAIL reset_d_pc: got %h want 0", d_pc); else pass_cnt++;
        total++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_fill_backpressure();
        idle_inputs();
        f_valid = 1'b1; f_pc = 32'h0; f_ins = 32'h00500093;
        tick();
        f_pc = 32'h4; f_ins = 32'h00A00113;
        tick();
        total++; if (count !== CW'(2)) $display("FAIL fill_count: got %0d want 2", count); else pass_cnt++;
        total++; if (f_ready !== 1'b0) $display("FAIL fill_f_ready: got %b want 0", f_ready); else pass_cnt++;
        f_pc = 32'h8; f_ins = 32'h00F00193;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (d_pc !== 32'h0 || d_ins !== 32'h00500093 || d_valid !== 1'b1)
                $display("FAIL stall_hold[%0d]: got pc=%h ins=%h v=%b want pc=0 ins=00500093 v=1", i, d_pc, d_ins, d_valid);
            else pass_cnt++;
            total++; if (count !== CW'(2)) $display("FAIL stall_count[%0d]: got %0d want 2", i, count); else pass_cnt++;
        end
        f_valid = 1'b0;
    endtask

    task automatic test_drain();
        d_ready = 1'b1;
        tick();
        total++; if (d_pc !== 32'h4 || d_ins !== 32'h00A00113) $display("FAIL drain_second: got pc=%h ins=%h want 4/00A00113", d_pc, d_ins); else pass_cnt++;
        tick();
        total++; if (d_valid !== 1'b0) $display("FAIL drain_empty_valid: got %b want 0", d_valid); else pass_cnt++;
        total++; if (count !== '0) $display("FAIL drain_empty_count: got %0d want 0", count); else pass_cnt++;
        total++; if (d_ins !== NOP) $display("FAIL drain_nop: got %h want %h", d_ins, NOP); else pass_cnt++;
        d_ready = 1'b0;
    endtask

    task automatic test_streaming();
        idle_inputs();
        f_valid = 1'b1; d_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f_pc  = 32'(4 * i);
            f_ins = $urandom;
            tick();
            total++;
            if (d_valid !== 1'b1 || d_pc !== 32'(4 * i) || d_ins !== f_ins)
                $display("FAIL stream_pc[%0d]: got v=%b pc=%h ins=%h want pc=%h ins=%h", i, d_valid, d_pc, d_ins, 32'(4 * i), f_ins);
            else pass_cnt++;
            total++; if (count !== CW'(1)) $display("FAIL stream_count[%0d]: got %0d want 1", i, count); else pass_cnt++;
        end
        f_valid = 1'b0;
        tick();
        d_ready = 1'b0;
        total++; if (count !== '0) $display("FAIL stream_tail: got count %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_full_pop();
        idle_inputs();
        f_valid = 1'b1;
        f_pc = 32'h10; f_ins = $urandom; tick();
        f_pc = 32'h14; f_ins = $urandom; tick();
        f_pc = 32'h18; f_ins = $urandom; d_ready = 1'b1;
        total++; if (f_ready !== 1'b0) $display("FAIL fullpop_ready: got %b want 0", f_ready); else pass_cnt++;
        tick();
        f_valid = 1'b0; d_ready = 1'b0;
        total++; if (count !== CW'(1)) $display("FAIL fullpop_count: got %0d want 1", count); else pass_cnt++;
        total++; if (d_pc !== 32'h14) $display("FAIL fullpop_head: got %h want 14", d_pc); else pass_cnt++;
        d_ready = 1'b1; tick(); d_ready = 1'b0;
        total++; if (d_valid !== 1'b0) $display("FAIL fullpop_rejected: got v=%b pc=%h want empty", d_valid, d_pc); else pass_cnt++;
    endtask

    task automatic test_flush();
        bit seen;
        idle_inputs();
        popped.delete();
        f_valid = 1'b1;
        f_pc = 32'h20; f_ins = $urandom; tick();
        f_pc = 32'h24; f_ins = $urandom; tick();
        flush = 1'b1; d_ready = 1'b1; f_pc = 32'h100; f_ins = $urandom;
        tick();
        flush = 1'b0; d_ready = 1'b0;
        total++; if (count !== '0) $display("FAIL flush_count: got %0d want 0", count); else pass_cnt++;
        total++; if (d_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", d_valid); else pass_cnt++;
        f_pc = 32'h200; f_ins = 32'h00100093;
        tick();
        f_valid = 1'b0;
        total++; if (d_valid !== 1'b1 || d_pc !== 32'h200) $display("FAIL flush_repush: got v=%b pc=%h want 1/200", d_valid, d_pc); else pass_cnt++;
        d_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (d_valid && d_pc === 32'h100) seen = 1'b1;
            tick();
        end
        d_ready = 1'b0;
        foreach (popped[i]) if (popped[i] === 32'h100) seen = 1'b1;
        total++; if (seen) $display("FAIL flush_drop: got 0x100 emerging want never"); else pass_cnt++;
    endtask

    task automatic test_random();
        int errs;
        logic [XLEN-1:0] e_pc, e_ins;
        logic [CW-1:0]   e_cnt;
        errs = 0;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            f_valid = ($urandom_range(0, 3) != 0);
            d_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            f_pc    = $urandom;
            f_ins   = $urandom;
            tick();
            e_cnt = CW'(q_pc.size());
            e_pc  = (q_pc.size() > 0) ? q_pc[0]  : '0;
            e_ins = (q_pc.size() > 0) ? q_ins[0] : NOP;
            total++;
            if (count !== e_cnt || d_valid !== (q_pc.size() > 0) || f_ready !== (q_pc.size() < DEPTH)
                || d_pc !== e_pc || d_ins !== e_ins) begin
                errs++;
                if (errs < 10)
                    $display("FAIL random[%0d]: got cnt=%0d v=%b r=%b pc=%h ins=%h want cnt=%0d pc=%h ins=%h",
                             i, count, d_valid, f_ready, d_pc, d_ins, e_cnt, e_pc, e_ins);
            end else pass_cnt++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_drain();
        test_streaming();
        test_full_pop();
        test_flush();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
